// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge.
// FSM state encoding, EX stall index, bus address alignment.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } dmem_state_t;

    localparam int STALL_EX        = 2;
    localparam int DBUS_ALIGN_BITS = 3;

endpackage

// File: rtl/dmem_bridge_watchdog.sv
// Response watchdog: counts enabled cycles, pulses fire in the TIMEOUT-th one.
// Latency: fire is combinational from the count; TIMEOUT=0 never fires.
// Backpressure: none; clr has priority over en.
module dmem_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic fire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (TIMEOUT != 0)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of enabled cycles already elapsed, so the
    // TIMEOUT-th enabled cycle is the one that sees LAST.
    assign fire = en && (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the EX-stage SRAM-style data request onto a valid/ready bus and stalls EX until the response.
// Latency: en at c, ready at c+1, resp at c+2 -> DONE at c+3 (3 stall cycles), rdata registered.
// Backpressure: request held stable while dbus_req_ready=0; EX held via stallreq_dmem until the response.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          stall,
    input  logic                data_sram_en,
    input  logic                data_sram_we,
    input  logic [DATA_W/8-1:0] data_sram_sel,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic [DATA_W-1:0]   data_sram_rdata,
    output logic                stallreq_dmem,
    output logic                dbus_req_valid,
    input  logic                dbus_req_ready,
    output logic                dbus_req_we,
    output logic [ADDR_W-1:0]   dbus_req_addr,
    output logic [DATA_W/8-1:0] dbus_req_wstrb,
    output logic [DATA_W-1:0]   dbus_req_wdata,
    input  logic                dbus_resp_valid,
    input  logic [DATA_W-1:0]   dbus_resp_rdata,
    output logic                dbus_err
);

    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] wdata;
    } req_t;

    dmem_state_t       state_q;
    dmem_state_t       state_d;
    req_t              req_q;
    req_t              req_d;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic              err_q;
    logic              err_d;

    logic wd_clr;
    logic wd_en;
    logic wd_fire;

    assign wd_en  = (state_q == WAIT_R);
    assign wd_clr = (state_q != WAIT_R);

    dmem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr),
        .en    (wd_en),
        .fire  (wd_fire)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (data_sram_en) begin
                    req_d.we    = data_sram_we;
                    req_d.addr  = {data_sram_addr[ADDR_W-1:DBUS_ALIGN_BITS], {DBUS_ALIGN_BITS{1'b0}}};
                    req_d.strb  = data_sram_sel;
                    req_d.wdata = data_sram_wdata;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (dbus_req_ready) begin
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                // A response landing on the timeout cycle still counts as a success.
                if (dbus_resp_valid) begin
                    if (!req_q.we) begin
                        rdata_d = dbus_resp_rdata;
                    end
                    state_d = DONE;
                end else if (wd_fire) begin
                    err_d = 1'b1;
                    if (!req_q.we) begin
                        rdata_d = '0;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // EX still presents the finished request until it advances; never reissue it.
                if (!stall[STALL_EX]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign stallreq_dmem   = ((state_q == IDLE) && data_sram_en) || (state_q == REQ) || (state_q == WAIT_R);
    assign dbus_req_valid  = (state_q == REQ);
    assign dbus_req_we     = req_q.we;
    assign dbus_req_addr   = req_q.addr;
    assign dbus_req_wstrb  = req_q.strb;
    assign dbus_req_wdata  = req_q.wdata;
    assign data_sram_rdata = rdata_q;
    assign dbus_err        = err_q;

    logic unused_ok;
    assign unused_ok = ^{stall[5:STALL_EX+1], stall[STALL_EX-1:0], data_sram_addr[DBUS_ALIGN_BITS-1:0]};

    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        dbus_req_valid && !dbus_req_ready |=> dbus_req_valid && $stable(req_q));

    a_done_no_stall: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == DONE) |-> !stallreq_dmem);

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge with a transaction-level reference model checked every cycle.
module tb_dmem_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  stall = '0;
    logic        data_sram_en = 1'b0;
    logic        data_sram_we = 1'b0;
    logic [7:0]  data_sram_sel = '0;
    logic [63:0] data_sram_addr = '0;
    logic [63:0] data_sram_wdata = '0;
    logic [63:0] data_sram_rdata;
    logic        stallreq_dmem;
    logic        dbus_req_valid;
    logic        dbus_req_ready = 1'b0;
    logic        dbus_req_we;
    logic [63:0] dbus_req_addr;
    logic [7:0]  dbus_req_wstrb;
    logic [63:0] dbus_req_wdata;
    logic        dbus_resp_valid = 1'b0;
    logic [63:0] dbus_resp_rdata = '0;
    logic        dbus_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_bridge #(
        .ADDR_W  (64),
        .DATA_W  (64),
        .TIMEOUT (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_sel   (data_sram_sel),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq_dmem   (stallreq_dmem),
        .dbus_req_valid  (dbus_req_valid),
        .dbus_req_ready  (dbus_req_ready),
        .dbus_req_we     (dbus_req_we),
        .dbus_req_addr   (dbus_req_addr),
        .dbus_req_wstrb  (dbus_req_wstrb),
        .dbus_req_wdata  (dbus_req_wdata),
        .dbus_resp_valid (dbus_resp_valid),
        .dbus_resp_rdata (dbus_resp_rdata),
        .dbus_err        (dbus_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, plus a "held" flag while EX sits on a finished one.
    bit          m_busy = 0;
    bit          m_acc = 0;
    bit          m_held = 0;
    bit          m_we = 0;
    logic [63:0] m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic [7:0]  m_sel = '0;
    int          m_wait = 0;
    logic [63:0] m_rdata = '0;
    bit          m_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_acc = 0; m_held = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_sel = '0; m_wait = 0;
            m_rdata = '0; m_err = 0;
        end else if (m_held) begin
            if (!stall[2]) m_held = 0;
        end else if (!m_busy) begin
            if (data_sram_en) begin
                m_busy = 1; m_acc = 0; m_wait = 0;
                m_we = data_sram_we;
                m_addr = data_sram_addr & ~64'h7;
                m_sel = data_sram_sel;
                m_wdata = data_sram_wdata;
            end
        end else if (!m_acc) begin
            if (dbus_req_ready) m_acc = 1;
        end else begin
            m_wait++;
            if (dbus_resp_valid) begin
                if (!m_we) m_rdata = dbus_resp_rdata;
                m_busy = 0; m_held = 1;
            end else if (m_wait == TMO) begin
                m_err = 1;
                if (!m_we) m_rdata = '0;
                m_busy = 0; m_held = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_stallreq", stallreq_dmem, m_busy || (data_sram_en && !m_held));
        chk("m_valid", dbus_req_valid, m_busy && !m_acc);
        if (m_busy && !m_acc) begin
            chk("m_addr", dbus_req_addr, m_addr);
            chk("m_wstrb", dbus_req_wstrb, m_sel);
            chk("m_we", dbus_req_we, m_we);
            if (m_we) chk("m_wdata", dbus_req_wdata, m_wdata);
        end
        chk("m_rdata", data_sram_rdata, m_rdata);
        chk("m_err", dbus_err, m_err);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit w, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
        data_sram_en = 1'b1;
        data_sram_we = w;
        data_sram_addr = a;
        data_sram_sel = s;
        data_sram_wdata = d;
    endtask

    // Plays the bus agent; returns at the negedge of the cycle where stallreq has dropped.
    task automatic run_txn(input logic [63:0] exp_addr, input int rdy_dly, input int rsp_dly,
                           input logic [63:0] rd, output int sc, output int vc, output int fv);
        bit accepted = 0;
        bit done = 0;
        int wc = 0;
        int cyc = 0;
        sc = 0; vc = 0; fv = -1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            dbus_req_ready = 1'b0;
            dbus_resp_valid = 1'b0;
            if (accepted && !stallreq_dmem) begin
                done = 1;
            end else begin
                if (stallreq_dmem) sc++;
                if (dbus_req_valid) begin
                    vc++;
                    if (vc == 1) fv = cyc;
                    chk("txn_addr", dbus_req_addr, exp_addr);
                    chk("txn_wstrb", dbus_req_wstrb, data_sram_sel);
                    chk("txn_wdata", dbus_req_wdata, data_sram_wdata);
                    chk("txn_we", dbus_req_we, data_sram_we);
                    if (vc > rdy_dly) begin
                        dbus_req_ready = 1'b1;
                        accepted = 1;
                    end
                end else if (accepted) begin
                    wc++;
                    if (rsp_dly >= 0 && wc == rsp_dly + 1) begin
                        dbus_resp_valid = 1'b1;
                        dbus_resp_rdata = rd;
                    end
                end
            end
            cyc++;
        end
        if (!done) chk("txn_bound", 64'd0, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit");
        $fatal(1);
    end

    initial begin
        int sc, vc, fv;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", dbus_req_valid, 0);
        chk("rst_rdata", data_sram_rdata, 0);
        chk("rst_err", dbus_err, 0);
        chk("rst_stallreq_en0", stallreq_dmem, 0);
        #1 data_sram_en = 1'b1;
        #1 chk("rst_stallreq_en1", stallreq_dmem, 1);
        data_sram_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // single load, immediate ready and response
        set_req(0, 64'h8000_100D, 8'h20, 64'h0);
        run_txn(64'h8000_1008, 0, 0, 64'h1122_3344_5566_7788, sc, vc, fv);
        chk("t1_stall_cycles", sc, 3);
        chk("t1_valid_cycles", vc, 1);
        chk("t1_rdata", data_sram_rdata, 64'h1122_3344_5566_7788);
        step();
        data_sram_en = 1'b0;
        @(negedge clk);
        chk("t1_rdata_hold", data_sram_rdata, 64'h1122_3344_5566_7788);
        step();

        // store with ready held low for 4 cycles; response data must be ignored
        set_req(1, 64'h8000_2000, 8'hF0, 64'hDEAD_BEEF_0000_0000);
        run_txn(64'h8000_2000, 4, 0, 64'h5555_5555_5555_5555, sc, vc, fv);
        chk("t2_stall_cycles", sc, 7);
        chk("t2_valid_cycles", vc, 5);
        chk("t2_rdata_kept", data_sram_rdata, 64'h1122_3344_5566_7788);
        step();
        data_sram_en = 1'b0;
        step();

        // EX held in DONE: no reissue, no stall
        set_req(0, 64'h8000_3007, 8'h80, 64'h0);
        run_txn(64'h8000_3000, 0, 0, 64'hA5A5_A5A5_0000_1111, sc, vc, fv);
        chk("t3_stall_cycles", sc, 3);
        stall = 6'b000100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", dbus_req_valid, 0);
            chk("t3_hold_stallreq", stallreq_dmem, 0);
        end
        stall = 6'b000000;
        step();
        data_sram_en = 1'b0;
        @(negedge clk);
        chk("t3_idle_valid", dbus_req_valid, 0);
        chk("t3_rdata", data_sram_rdata, 64'hA5A5_A5A5_0000_1111);
        step();

        // back-to-back loads with en held
        set_req(0, 64'h8000_4000, 8'hFF, 64'h0);
        run_txn(64'h8000_4000, 0, 0, 64'h0102_0304_0506_0708, sc, vc, fv);
        chk("t4a_stall_cycles", sc, 3);
        step();
        data_sram_addr = 64'h8000_4010;
        data_sram_sel = 8'h0F;
        run_txn(64'h8000_4010, 1, 0, 64'h0A0B_0C0D_0E0F_1011, sc, vc, fv);
        chk("t4b_first_valid", fv, 1);
        chk("t4b_stall_cycles", sc, 4);
        chk("t4b_rdata", data_sram_rdata, 64'h0A0B_0C0D_0E0F_1011);
        step();
        data_sram_en = 1'b0;
        step();

        // response on the exact timeout cycle wins
        set_req(0, 64'h8000_5000, 8'hFF, 64'h0);
        run_txn(64'h8000_5000, 0, TMO - 1, 64'h0BAD_F00D_0000_0001, sc, vc, fv);
        chk("t5a_stall_cycles", sc, 10);
        chk("t5a_err", dbus_err, 0);
        chk("t5a_rdata", data_sram_rdata, 64'h0BAD_F00D_0000_0001);
        step();
        data_sram_en = 1'b0;
        step();

        // no response: watchdog fires after 8 wait cycles
        set_req(0, 64'h8000_5000, 8'hFF, 64'h0);
        run_txn(64'h8000_5000, 0, -1, 64'h0, sc, vc, fv);
        chk("t5b_stall_cycles", sc, 10);
        chk("t5b_err", dbus_err, 1);
        chk("t5b_rdata", data_sram_rdata, 0);
        step();
        data_sram_en = 1'b0;
        step();

        // error is sticky across a later good load
        set_req(0, 64'h8000_5008, 8'hFF, 64'h0);
        run_txn(64'h8000_5008, 0, 0, 64'h7777_6666_5555_4444, sc, vc, fv);
        chk("t5c_err_sticky", dbus_err, 1);
        chk("t5c_rdata", data_sram_rdata, 64'h7777_6666_5555_4444);
        step();
        data_sram_en = 1'b0;
        step();

        // async reset while waiting for a response
        set_req(0, 64'h8000_6000, 8'hFF, 64'h0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_req_valid", dbus_req_valid, 1);
        dbus_req_ready = 1'b1;
        @(negedge clk);
        dbus_req_ready = 1'b0;
        chk("t6_wait_stallreq", stallreq_dmem, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", dbus_req_valid, 0);
        chk("t6_rst_rdata", data_sram_rdata, 0);
        chk("t6_rst_err", dbus_err, 0);
        chk("t6_rst_stallreq_en", stallreq_dmem, 1);
        data_sram_en = 1'b0;
        #1 chk("t6_rst_stallreq_noen", stallreq_dmem, 0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        dbus_resp_valid = 1'b1;
        dbus_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        dbus_resp_valid = 1'b0;
        #1;
        chk("t6_stray_rdata", data_sram_rdata, 0);
        chk("t6_stray_valid", dbus_req_valid, 0);
        chk("t6_stray_stallreq", stallreq_dmem, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
